// File: rtl/experiment4.sv
// experiment4: three level-sensitive latches (basic SR, gated SR, D) alongside
// a 16-bit left-shifting parallel-load register. All storage is cleared
// asynchronously by rst_n.
module experiment4 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS,
    input  logic        SR,
    output logic        SQ,
    output logic        SQn,
    input  logic        SES,
    input  logic        SER,
    input  logic        SEE,
    output logic        SEQ,
    output logic        SEQn,
    input  logic        D,
    input  logic        Clock,
    output logic        DQ,
    output logic        DQn,
    input  logic [15:0] I,
    input  logic        load,
    output logic        shift_out
);

    logic        sr_q;
    logic        se_q;
    logic        d_q;
    logic [15:0] sreg;

    logic sr_forbid;
    logic se_open;
    logic se_forbid;

    // SS=SR=1 forces both outputs low and leaves 0 stored.
    assign sr_forbid = SS & SR;
    assign se_open   = SEE & (SES | SER);
    assign se_forbid = SEE & SES & SER;

    // Basic SR storage: open whenever either input is high, stores S & ~R.
    always_latch begin
        if (!rst_n) begin
            sr_q <= 1'b0;
        end else if (SS | SR) begin
            sr_q <= SS & ~SR;
        end
    end

    // Gated SR storage: same rule as the basic latch, qualified by SEE.
    always_latch begin
        if (!rst_n) begin
            se_q <= 1'b0;
        end else if (se_open) begin
            se_q <= SES & ~SER;
        end
    end

    // D latch: transparent while Clock is high.
    always_latch begin
        if (!rst_n) begin
            d_q <= 1'b0;
        end else if (Clock) begin
            d_q <= D;
        end
    end

    // Shift register: load has priority, otherwise shift left with zero fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg <= 16'h0000;
        end else if (load) begin
            sreg <= I;
        end else begin
            sreg <= {sreg[14:0], 1'b0};
        end
    end

    // Latch outputs; reset masks the forbidden-state low on the Qn side.
    always_comb begin
        SQ        = sr_q;
        SQn       = ~sr_q & ~(sr_forbid & rst_n);
        SEQ       = se_q;
        SEQn      = ~se_q & ~(se_forbid & rst_n);
        DQ        = d_q;
        DQn       = ~d_q;
        shift_out = sreg[15];
    end

endmodule

// File: tb/tb_experiment4.sv
// Self-checking bench for experiment4: directed sequences plus randomized
// stimulus against a behavioural model of the latches and shift register.
module tb_experiment4;

    logic        clk;
    logic        rst_n;
    logic        SS, SR, SQ, SQn;
    logic        SES, SER, SEE, SEQ, SEQn;
    logic        D, Clock, DQ, DQn;
    logic [15:0] I;
    logic        load;
    logic        shift_out;

    int checks;
    int errors;

    // Model state.
    bit        m_sr;
    bit        m_se;
    bit        m_d;
    bit [15:0] m_reg;

    experiment4 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .SS        (SS),
        .SR        (SR),
        .SQ        (SQ),
        .SQn       (SQn),
        .SES       (SES),
        .SER       (SER),
        .SEE       (SEE),
        .SEQ       (SEQ),
        .SEQn      (SEQn),
        .D         (D),
        .Clock     (Clock),
        .DQ        (DQ),
        .DQn       (DQn),
        .I         (I),
        .load      (load),
        .shift_out (shift_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset();
        rst_n = 1'b0;
        SS = 1'b1; SR = 1'b1; SES = 1'b1; SER = 1'b0; SEE = 1'b1;
        D = 1'b1; Clock = 1'b1; I = 16'hFFFF; load = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({SQ, SQn, SEQ, SEQn, DQ, DQn, shift_out} !== 7'b0101010) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0101010",
                     {SQ, SQn, SEQ, SEQn, DQ, DQn, shift_out});
        end
        SS = 1'b0; SR = 1'b0; SES = 1'b0; SER = 1'b0; SEE = 1'b0;
        D = 1'b0; Clock = 1'b0; load = 1'b0; I = 16'h0000;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({SQ, SQn, SEQ, SEQn, DQ, DQn, shift_out} !== 7'b0101010) begin
            errors++;
            $display("FAIL reset_release: got %b expected 0101010",
                     {SQ, SQn, SEQ, SEQn, DQ, DQn, shift_out});
        end
    endtask

    task automatic test_sr_sequence();
        logic [1:0] ins [6] = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b11, 2'b00};
        logic [1:0] exp [6] = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b00, 2'b01};
        for (int i = 0; i < 6; i++) begin
            {SS, SR} = ins[i];
            #1;
            checks++;
            if ({SQ, SQn} !== exp[i]) begin
                errors++;
                $display("FAIL sr_seq[%0d]: got SQ/SQn=%b expected %b", i, {SQ, SQn}, exp[i]);
            end
        end
    endtask

    task automatic test_gated();
        SEE = 1'b1; SES = 1'b1; SER = 1'b0;
        #1;
        checks++;
        if ({SEQ, SEQn} !== 2'b10) begin
            errors++;
            $display("FAIL gated_set: got %b expected 10", {SEQ, SEQn});
        end
        SEE = 1'b0; SES = 1'b0; SER = 1'b1;
        #1;
        checks++;
        if ({SEQ, SEQn} !== 2'b10) begin
            errors++;
            $display("FAIL gated_hold: got %b expected 10", {SEQ, SEQn});
        end
        SEE = 1'b1;
        #1;
        checks++;
        if ({SEQ, SEQn} !== 2'b01) begin
            errors++;
            $display("FAIL gated_reset: got %b expected 01", {SEQ, SEQn});
        end
        SEE = 1'b0; SER = 1'b0;
        #1;
    endtask

    task automatic test_d_latch();
        Clock = 1'b1; D = 1'b1;
        #1;
        checks++;
        if ({DQ, DQn} !== 2'b10) begin
            errors++;
            $display("FAIL d_transparent: got %b expected 10", {DQ, DQn});
        end
        Clock = 1'b0;
        #1;
        D = 1'b0;
        #1;
        checks++;
        if ({DQ, DQn} !== 2'b10) begin
            errors++;
            $display("FAIL d_hold: got %b expected 10", {DQ, DQn});
        end
        Clock = 1'b1;
        #1;
        checks++;
        if ({DQ, DQn} !== 2'b01) begin
            errors++;
            $display("FAIL d_follow: got %b expected 01", {DQ, DQn});
        end
        Clock = 1'b0;
        #1;
    endtask

    // Load a word, then shift n times; exp[k] is shift_out after k shifts.
    task automatic run_shift(input logic [15:0] word, input int n, input string name);
        bit [15:0] v;
        @(negedge clk);
        I = word; load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        v = word;
        for (int k = 0; k <= n; k++) begin
            checks++;
            if (shift_out !== v[15]) begin
                errors++;
                $display("FAIL %s shift %0d: got %b expected %b", name, k, shift_out, v[15]);
            end
            if (k < n) begin
                @(posedge clk);
                #1;
                v = 16'((32'(v) * 2) % 65536);
            end
        end
    endtask

    task automatic test_shift_patterns();
        // 0101: ones appear after shifts 7 and 15 only, zeros from 16 on.
        run_shift(16'h0101, 18, "shift_0101");
        run_shift(16'hC000, 3, "shift_C000");
    endtask

    task automatic test_reset_mid_shift();
        @(negedge clk);
        SS = 1'b1; SES = 1'b1; SEE = 1'b1; D = 1'b1; Clock = 1'b1;
        I = 16'h8000; load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        SS = 1'b0; SES = 1'b0; SEE = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({SQ, SEQ, DQ, shift_out} !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset: got SQ,SEQ,DQ,shift_out=%b expected 0000",
                     {SQ, SEQ, DQ, shift_out});
        end
        Clock = 1'b0;
        #1;
        rst_n = 1'b1;
        run_shift(16'h001F, 12, "shift_001F");
    endtask

    // Latch model applied from the behavioural rules.
    task automatic test_latch_random();
        bit s, r, e, d, c;
        bit [5:0] exp;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        m_sr = 0; m_se = 0; m_d = 0;
        for (int i = 0; i < 200; i++) begin
            s = 1'($urandom); r = 1'($urandom);
            SS = s; SR = r;
            exp[5:4] = (s && r) ? 2'b00 : ((s) ? 2'b10 : (r ? 2'b01 : {m_sr, !m_sr}));
            m_sr = exp[5];
            s = 1'($urandom); r = 1'($urandom); e = 1'($urandom);
            SES = s; SER = r; SEE = e;
            if (e && s && r) exp[3:2] = 2'b00;
            else if (e && s) exp[3:2] = 2'b10;
            else if (e && r) exp[3:2] = 2'b01;
            else exp[3:2] = {m_se, !m_se};
            m_se = exp[3];
            d = 1'($urandom); c = 1'($urandom);
            D = d; Clock = c;
            if (c) m_d = d;
            exp[1:0] = {m_d, !m_d};
            #1;
            checks++;
            if ({SQ, SQn, SEQ, SEQn, DQ, DQn} !== exp) begin
                errors++;
                $display("FAIL latch_rand[%0d]: got %b expected %b", i,
                         {SQ, SQn, SEQ, SEQn, DQ, DQn}, exp);
            end
        end
        SS = 0; SR = 0; SES = 0; SER = 0; SEE = 0; Clock = 0;
    endtask

    task automatic test_shift_random();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        m_reg = 16'h0000;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            load = ($urandom_range(0, 5) == 0);
            I = 16'($urandom);
            @(posedge clk);
            m_reg = load ? I : 16'((32'(m_reg) * 2) % 65536);
            #1;
            checks++;
            if (shift_out !== m_reg[15]) begin
                errors++;
                $display("FAIL shift_rand[%0d]: got %b expected %b", i, shift_out, m_reg[15]);
            end
        end
        load = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_sr_sequence();
        test_gated();
        test_d_latch();
        test_shift_patterns();
        test_reset_mid_shift();
        test_latch_random();
        test_shift_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/experiment4.md
EXPERIMENT4 -- requirements
Module: experiment4

Interface
REQ-001 The block SHALL have one clock, `clk`; reset SHALL be asynchronous and active-low, on port `rst_n`.
REQ-002 Port list (name, direction, width, meaning):
- `clk`, in, 1: shift-register clock, rising edge.
- `rst_n`, in, 1: async active-low reset.
- `SS`, in, 1: basic SR latch set.
- `SR`, in, 1: basic SR latch reset.
- `SQ`, out, 1: basic SR latch Q.
- `SQn`, out, 1: basic SR latch Qn.
- `SES`, in, 1: gated SR latch set.
- `SER`, in, 1: gated SR latch reset.
- `SEE`, in, 1: gated SR latch enable, active-high.
- `SEQ`, out, 1: gated SR latch Q.
- `SEQn`, out, 1: gated SR latch Qn.
- `D`, in, 1: D latch data.
- `Clock`, in, 1: D latch level enable (data input, not a clock).
- `DQ`, out, 1: D latch Q.
- `DQn`, out, 1: D latch Qn.
- `I`, in, 16: parallel load word.
- `load`, in, 1: synchronous parallel-load select.
- `shift_out`, out, 1: serial output, equal to register bit 15.
REQ-003 Port order: `clk`, `rst_n`, `SS`, `SR`, `SQ`, `SQn`, `SES`, `SER`, `SEE`, `SEQ`, `SEQn`, `D`, `Clock`, `DQ`, `DQn`, `I`, `load`, `shift_out`.

Function
REQ-004 Basic SR latch, level-sensitive, no clock, active-high inputs:
- SS=1, SR=0: set, SQ=1.
- SS=0, SR=1: reset, SQ=0.
- SS=0, SR=0: hold.
REQ-005 Basic SR latch forbidden input SS=SR=1: SQ=0 and SQn=0 while asserted; the stored state becomes 0, so a later 00 holds SQ=0, SQn=1.
REQ-006 In every case other than SS=SR=1, SQn SHALL equal ~SQ.
REQ-007 Gated SR latch with SEE=1: SES/SER behave exactly as REQ-004 to REQ-006, applied to SEQ and SEQn.
REQ-008 Gated SR latch with SEE=0: hold regardless of SES/SER, with SEQn=~SEQ.
REQ-009 D latch: with Clock=1 it is transparent (DQ follows D combinationally); with Clock=0 it holds the last value; DQn SHALL always equal ~DQ.
REQ-010 All latch outputs SHALL respond combinationally to input changes, with zero cycle latency and no dependence on `clk`.
REQ-011 Shift register: 16-bit register `sreg`, updated only on rising `clk` when `rst_n`=1.
REQ-012 load=1 at an edge: sreg <= I, with priority over shifting.
REQ-013 load=0 at an edge: sreg <= {sreg[14:0], 1'b0}, i.e. shift left with zero fill.
REQ-014 `shift_out` SHALL be sreg[15] continuously, with no extra register stage.
REQ-015 After a load followed by 16 or more shifts, sreg SHALL be 0 and `shift_out` SHALL be 0; there is no wrap-around.
REQ-016 Simultaneous `load` change and `clk` edge: the value sampled at the edge governs.

Reset
REQ-017 While `rst_n`=0, asynchronously: sreg=0 and shift_out=0; SQ=0, SQn=1; SEQ=0, SEQn=1; DQ=0, DQn=1.
REQ-018 Reset SHALL override all latch and register inputs, including a D latch whose enable is high.
REQ-019 On `rst_n` deassertion, latches SHALL immediately resume REQ-004 to REQ-009 behaviour, and the register SHALL act at the next rising `clk`.
REQ-020 Reset asserted mid-shift SHALL clear sreg immediately, without waiting for a clock edge.

Verification
REQ-021 SR latch sequence, SS/SR = 10 -> 00 -> 01 -> 00 -> 11 -> 00 -> required SQ/SQn = 1/0, 1/0, 0/1, 0/1, 0/0, 0/1.
REQ-022 Gated SR latch: SEE=1, SES=1, SER=0 -> SEQ=1; then SEE=0, SES=0, SER=1 -> SEQ stays 1; then SEE=1 -> SEQ=0, SEQn=1.
REQ-023 D latch: Clock=1, D=1 -> DQ=1; Clock=0, D=0 -> DQ stays 1; Clock=1 -> DQ=0, DQn=1.
REQ-024 Shift, I=16'h0101: load then shift; shift_out=0 after the load, 1 after shift 7, 0 after shift 8, 1 after shift 15, 0 from shift 16 onward.
REQ-025 Shift, I=16'hC000: shift_out=1 after the load, 1 after shift 1, 0 after shift 2.
REQ-026 Shift, I=16'h8000: load, 1 shift, then assert `rst_n`=0 mid-cycle -> shift_out=0 immediately and all latch Q outputs 0; release `rst_n`, load 16'h001F -> shift_out=0 until shift 11, which gives 1.
